scan_decoder: RTL and testbench



---
 rtl/scan_decoder_pkg.sv | 23 ++
 rtl/dwell_timer.sv | 35 +++
 rtl/scan_decoder.sv | 162 ++++++++++++++++
 tb/tb_scan_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block: FSM state encoding,
// mode constants and a one-hot helper sized for the widest supported select.
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      BLANK = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Callers cast the result down to their own 2^SEL_W output width.
   localparam int MAX_SEL_W = 8;
   localparam int MAX_OUT_W = 1 << MAX_SEL_W;

   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that times how long the scan holds each index.
// zero is taken from the registered count, so it is valid all cycle long.
module dwell_timer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [DWELL_W-1:0] value,
   input  logic               dec,
   output logic               zero
);

   logic [DWELL_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (dec && !zero) begin
         count_d = count_q - DWELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with a scan sequencer. Defining
// SCAN_DECODER_BLANK_EN inserts a one-cycle all-zero BLANK between indices.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  start,
   input  logic [DWELL_W-1:0]    dwell,
   output logic [(1<<SEL_W)-1:0] dout,
   output logic [SEL_W-1:0]      idx,
   output logic                  busy,
   output logic                  wrap
);

   localparam int OUT_W = 1 << SEL_W;
   typedef logic [OUT_W-1:0] dout_t;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   dout_t              dout_q, dout_d;
   logic               busy_q, busy_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;

   logic               timer_load;
   logic [DWELL_W-1:0] timer_value;
   logic               timer_dec;
   logic               timer_zero;

   logic               scan_ok;
   logic [SEL_W-1:0]   idx_next;
   dout_t              idle_dout;

   // Leaving scan mode or dropping en at any edge aborts to IDLE.
   assign scan_ok   = en && (mode == MODE_SCAN);
   assign idx_next  = idx_q + SEL_W'(1);
   assign idle_dout = (en && (mode == MODE_DIRECT)) ? dout_t'(onehot(MAX_SEL_W'(sel))) : '0;

   dwell_timer #(
      .DWELL_W(DWELL_W)
   ) u_dwell_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (timer_load),
      .value(timer_value),
      .dec  (timer_dec),
      .zero (timer_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         dout_q      <= '0;
         busy_q      <= 1'b0;
         wrap_q      <= 1'b0;
         dwell_lat_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dout_q      <= dout_d;
         busy_q      <= busy_d;
         wrap_q      <= wrap_d;
         dwell_lat_q <= dwell_lat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (scan_ok && start) begin
               state_d = DWELL;
            end
         end
         DWELL: begin
            if (!scan_ok) begin
               state_d = IDLE;
            end
`ifdef SCAN_DECODER_BLANK_EN
            else if (timer_zero) begin
               state_d = BLANK;
            end
         end
         BLANK: begin
            state_d = scan_ok ? DWELL : IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      idx_d       = idx_q;
      dout_d      = dout_q;
      busy_d      = 1'b0;
      wrap_d      = 1'b0;
      dwell_lat_d = dwell_lat_q;
      timer_load  = 1'b0;
      timer_value = dwell_lat_q;
      timer_dec   = 1'b0;
      case (state_q)
         IDLE: begin
            dout_d = idle_dout;
            if (scan_ok && start) begin
               idx_d       = '0;
               dout_d      = dout_t'(onehot('0));
               busy_d      = 1'b1;
               dwell_lat_d = dwell;
               timer_load  = 1'b1;
               timer_value = dwell;
            end
         end
         DWELL: begin
            if (!scan_ok) begin
               dout_d = idle_dout;
            end else begin
               busy_d = 1'b1;
               if (!timer_zero) begin
                  timer_dec = 1'b1;
               end else begin
`ifdef SCAN_DECODER_BLANK_EN
                  dout_d = '0;
`else
                  idx_d      = idx_next;
                  dout_d     = dout_t'(onehot(MAX_SEL_W'(idx_next)));
                  timer_load = 1'b1;
                  wrap_d     = (idx_q == '1);
`endif
               end
            end
         end
`ifdef SCAN_DECODER_BLANK_EN
         BLANK: begin
            if (!scan_ok) begin
               dout_d = idle_dout;
            end else begin
               busy_d     = 1'b1;
               idx_d      = idx_next;
               dout_d     = dout_t'(onehot(MAX_SEL_W'(idx_next)));
               timer_load = 1'b1;
               wrap_d     = (idx_q == '1);
            end
         end
`endif
         default: dout_d = '0;
      endcase
   end

   assign dout = dout_q;
   assign idx  = idx_q;
   assign busy = busy_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed testbench for scan_decoder (SEL_W=3, DWELL_W=8); scan expectations
// come from a closed-form position model and follow SCAN_DECODER_BLANK_EN.
module tb_scan_decoder;

   localparam int SEL_W   = 3;
   localparam int DWELL_W = 8;
   localparam int OUT_W   = 1 << SEL_W;
`ifdef SCAN_DECODER_BLANK_EN
   localparam int BLANK_CYC = 1;
`else
   localparam int BLANK_CYC = 0;
`endif

   logic               clk;
   logic               rst_n;
   logic               en;
   logic               mode;
   logic [SEL_W-1:0]   sel;
   logic               start;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   dout;
   logic [SEL_W-1:0]   idx;
   logic               busy;
   logic               wrap;

   int checkCount = 0;
   int errorCount = 0;

   scan_decoder #(
      .SEL_W  (SEL_W),
      .DWELL_W(DWELL_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .mode (mode),
      .sel  (sel),
      .start(start),
      .dwell(dwell),
      .dout (dout),
      .idx  (idx),
      .busy (busy),
      .wrap (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic m, input logic [SEL_W-1:0] s,
                                input logic st, input logic [DWELL_W-1:0] dw);
      en    = e;
      mode  = m;
      sel   = s;
      start = st;
      dwell = dw;
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // Cycle t counts from the edge that sampled start (t=0 shows index 0).
   task automatic checkScanCycle(input string tag, input int dw, input int t);
      int p, pos, i, r;
      logic [31:0] expDout, expWrap;
      p       = dw + 1 + BLANK_CYC;
      pos     = t % (OUT_W * p);
      i       = pos / p;
      r       = pos % p;
      expDout = (BLANK_CYC == 1 && r == p - 1) ? 32'h0 : (32'h1 << i);
      expWrap = (t > 0 && pos == 0) ? 32'h1 : 32'h0;
      checkOutput($sformatf("%s t%0d dout", tag, t), 32'(dout), expDout);
      checkOutput($sformatf("%s t%0d idx", tag, t), 32'(idx), 32'(i));
      checkOutput($sformatf("%s t%0d busy", tag, t), 32'(busy), 32'h1);
      checkOutput($sformatf("%s t%0d wrap", tag, t), 32'(wrap), expWrap);
   endtask

   task automatic abortAndCheck(input string tag);
      applyStimulus(1'b0, 1'b1, '0, 1'b0, '0);
      stepClk();
      checkOutput({tag, " abort dout"}, 32'(dout), 32'h0);
      checkOutput({tag, " abort busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      int p;
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      #3;
      checkOutput("reset dout", 32'(dout), 32'h0);
      checkOutput("reset idx", 32'(idx), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset wrap", 32'(wrap), 32'h0);
      stepClk();
      stepClk();
      rst_n = 1'b1;

      $display("[TB] direct decode");
      applyStimulus(1'b1, 1'b0, 3'd5, 1'b0, '0);
      stepClk();
      checkOutput("direct sel5", 32'(dout), 32'h20);
      checkOutput("direct busy", 32'(busy), 32'h0);
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, '0);
      stepClk();
      checkOutput("direct sel0", 32'(dout), 32'h01);
      applyStimulus(1'b1, 1'b0, 3'd7, 1'b0, '0);
      stepClk();
      checkOutput("direct sel7", 32'(dout), 32'h80);
      applyStimulus(1'b0, 1'b0, 3'd7, 1'b0, '0);
      stepClk();
      checkOutput("direct en0", 32'(dout), 32'h00);

      applyStimulus(1'b0, 1'b1, 3'd2, 1'b1, 8'd3);
      stepClk();
      checkOutput("start en0 busy", 32'(busy), 32'h0);
      checkOutput("start en0 dout", 32'(dout), 32'h0);

      $display("[TB] scan dwell=2, start held high, sel toggling");
      applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 8'd2);
      stepClk();
      p = OUT_W * (3 + BLANK_CYC);
      for (int t = 0; t <= 2 * p; t++) begin
         checkScanCycle("scan dw2", 2, t);
         sel = 3'(t);
         stepClk();
      end
      abortAndCheck("scan dw2");

      $display("[TB] scan dwell=0, dwell changed mid-scan");
      applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 8'd0);
      stepClk();
      start = 1'b0;
      p = OUT_W * (1 + BLANK_CYC);
      for (int t = 0; t <= 3 * p; t++) begin
         checkScanCycle("scan dw0", 0, t);
         if (t == 5) dwell = 8'd5;
         stepClk();
      end
      abortAndCheck("scan dw0");

      $display("[TB] abort at idx 3 via mode=0");
      applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 8'd1);
      stepClk();
      p = 2 + BLANK_CYC;
      for (int t = 0; t <= 3 * p; t++) begin
         checkScanCycle("scan dw1", 1, t);
         if (t < 3 * p) stepClk();
      end
      applyStimulus(1'b1, 1'b0, 3'd6, 1'b1, 8'd1);
      stepClk();
      checkOutput("abort dout", 32'(dout), 32'h40);
      checkOutput("abort busy", 32'(busy), 32'h0);
      checkOutput("abort idx", 32'(idx), 32'h3);
      checkOutput("abort wrap", 32'(wrap), 32'h0);
      start = 1'b0;
      stepClk();

      $display("[TB] asynchronous reset mid-scan at idx 4");
      applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 8'd0);
      stepClk();
      start = 1'b0;
      p = 1 + BLANK_CYC;
      for (int t = 0; t <= 4 * p; t++) begin
         checkScanCycle("scan rst", 0, t);
         if (t < 4 * p) stepClk();
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async rst dout", 32'(dout), 32'h0);
      checkOutput("async rst idx", 32'(idx), 32'h0);
      checkOutput("async rst busy", 32'(busy), 32'h0);
      checkOutput("async rst wrap", 32'(wrap), 32'h0);
      stepClk();
      checkOutput("held rst busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      stepClk();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
